expr_result_unpacker: RTL and testbench
=======================================

EXPR_RESULT_UNPACKER -- requirements
Module: expr_result_unpacker

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  packed result vector available.
REQ-004 in_ready  output  1  block can accept a vector.
REQ-005 in_data  input  90  packed vector {y0,y1,...,y17}, y0 in MSBs.
REQ-006 out_valid  output  1  field beat valid.
REQ-007 out_ready  input  1  downstream accepts beat.
REQ-008 out_idx  output  5  field index 0..17.
REQ-009 out_data  output  8  field value, extended to 8 bits.
REQ-010 out_width  output  3  field width, 4/5/6.
REQ-011 out_last  output  1  high on beat idx 17.
REQ-012 frame_cnt  output  16  count of completed vectors.

Function
REQ-013 The field layout SHALL follow a 30-bit group of widths 4,5,6,4,5,6 repeated three times, MSB-first: y0=[89:86], y1=[85:81], y2=[80:75], y3=[74:71], y4=[70:66], y5=[65:60], y6..y11 at [59:30], y12..y17 at [29:0].
REQ-014 Fields y3,y4,y5,y9,y10,y11,y15,y16,y17 SHALL be sign-extended to 8 bits; all other fields SHALL be zero-extended.
REQ-015 The FSM SHALL have two states, IDLE and STREAM; reset state is IDLE.
REQ-016 In IDLE, in_ready SHALL be 1; in STREAM, in_ready SHALL be 0 (no combinational ready path).
REQ-017 In IDLE, in_valid&&in_ready SHALL capture in_data into a 90-bit holding register, clear the index counter to 0, and move to STREAM.
REQ-018 out_valid SHALL be 1 exactly while in STREAM, so the first beat (idx 0) is presented on the cycle after input acceptance (latency 1).
REQ-019 out_idx, out_data, out_width, out_last SHALL be driven from the holding register and index counter, and SHALL stay stable while out_valid&&!out_ready.
REQ-020 A beat SHALL be consumed only when out_valid&&out_ready; idx SHALL then increment by 1.
REQ-021 On the consumed beat with idx 17, the FSM SHALL return to IDLE, idx SHALL return to 0, and frame_cnt SHALL increment by 1.
REQ-022 frame_cnt SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-023 Changes on in_data while in STREAM SHALL have no effect on output beats.
REQ-024 In IDLE, out_idx, out_data, out_width and out_last SHALL be 0.
REQ-025 out_ready SHALL be ignored in IDLE; in_valid SHALL be ignored in STREAM.
REQ-026 out_ready held high SHALL yield 18 back-to-back beats; one vector therefore occupies 19 cycles from acceptance to the next in_ready, minimum.

Reset
REQ-027 rst_n=0 on a clock edge SHALL force IDLE, idx=0, holding register=0, frame_cnt=0, out_valid=0 and in_ready=1, including mid-stream; a partially streamed vector SHALL be discarded.
REQ-028 The first in_valid SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-029 in_data=0 except y0=4'hF -> beat 0 out_data=8'h0F, width=4; beats 1..17 out_data=0; last on idx 17; frame_cnt=1.
REQ-030 y3=4'b1000, y16=5'b01111, y17=6'b100001 -> idx3 out_data=8'hF8; idx16 out_data=8'h0F; idx17 out_data=8'hE1, out_last=1.
REQ-031 out_ready toggled 1,0,0,1,... during stream -> no beat lost or repeated; outputs stable during stalls; idx sequence 0..17 exactly once.
REQ-032 rst_n pulled low for 1 cycle at idx 9 -> next cycle IDLE, out_valid=0, frame_cnt=0; a new vector then restarts at idx 0.
REQ-033 Force frame_cnt to 16'hFFFF via 65535 frames (or a preloaded run), then complete one more vector -> frame_cnt=16'h0000.
REQ-034 in_valid held high continuously with two distinct vectors -> second accepted only on the cycle after beat 17 of the first is consumed; in_data change mid-stream has no effect on the current beats.

Source files
------------

// File: rtl/expr_result_unpacker.sv
// Unpacks a 90-bit vector of eighteen 4/5/6-bit fields into one field per beat,
// with sign or zero extension to 8 bits. A single vector is held while it streams.
module expr_result_unpacker #(
    // Value frame_cnt takes on reset; non-zero only to preload the wrap point.
    parameter logic [15:0] FrameCntInit = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [89:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [7:0]  out_data,
    output logic [2:0]  out_width,
    output logic        out_last,
    output logic [15:0] frame_cnt
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    localparam logic [4:0] LastIdx = 5'd17;

    state_e      state_q;
    logic [89:0] hold_q;
    logic [4:0]  idx_q;
    logic [15:0] frame_cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [4:0]  pos;
    logic [6:0]  grp_off;
    logic [6:0]  fld_off;
    logic [6:0]  base;
    logic [2:0]  wid;
    logic        sgn;
    logic [5:0]  top6;
    logic [5:0]  raw;
    logic [7:0]  ext;

    // Capture/stream FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            idx_q       <= '0;
            frame_cnt_q <= FrameCntInit;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        hold_q      <= in_data;
                        idx_q       <= '0;
                        state_q     <= StStream;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StStream: begin
                    if (out_ready) begin
                        if (idx_q == LastIdx) begin
                            idx_q       <= '0;
                            state_q     <= StIdle;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Locate the current field: 30-bit group, position in group, then extend.
    always_comb begin
        if (idx_q < 5'd6) begin
            pos     = idx_q;
            grp_off = 7'd0;
        end else if (idx_q < 5'd12) begin
            pos     = idx_q - 5'd6;
            grp_off = 7'd30;
        end else begin
            pos     = idx_q - 5'd12;
            grp_off = 7'd60;
        end
        case (pos)
            5'd0:    begin fld_off = 7'd0;  wid = 3'd4; sgn = 1'b0; end
            5'd1:    begin fld_off = 7'd4;  wid = 3'd5; sgn = 1'b0; end
            5'd2:    begin fld_off = 7'd9;  wid = 3'd6; sgn = 1'b0; end
            5'd3:    begin fld_off = 7'd15; wid = 3'd4; sgn = 1'b1; end
            5'd4:    begin fld_off = 7'd19; wid = 3'd5; sgn = 1'b1; end
            5'd5:    begin fld_off = 7'd24; wid = 3'd6; sgn = 1'b1; end
            default: begin fld_off = 7'd0;  wid = 3'd4; sgn = 1'b0; end
        endcase
        base = 7'd89 - grp_off - fld_off;
        // Take six bits starting at the field MSB, then drop the excess LSBs.
        top6 = hold_q[base -: 6];
        raw  = top6 >> (3'd6 - wid);
        ext  = {2'b00, raw};
        if (sgn && top6[5]) begin
            ext = ext | (8'hFF << wid);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_valid_q ? idx_q : 5'd0;
    assign out_data  = out_valid_q ? ext : 8'd0;
    assign out_width = out_valid_q ? wid : 3'd0;
    assign out_last  = out_valid_q && (idx_q == LastIdx);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Scoreboard bench for expr_result_unpacker: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_expr_result_unpacker;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] data;
        logic [2:0] width;
        logic       last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [89:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [7:0]  out_data;
    logic [2:0]  out_width;
    logic        out_last;
    logic [15:0] frame_cnt;

    // Second instance preloaded one frame short of the counter wrap.
    logic        w_in_valid;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [4:0]  w_out_idx;
    logic [7:0]  w_out_data;
    logic [2:0]  w_out_width;
    logic        w_out_last;
    logic [15:0] w_frame_cnt;

    int          total = 0;
    int          bad = 0;
    beat_t       sb[$];
    logic [15:0] exp_frames;

    logic        stall;
    beat_t       held;

    expr_result_unpacker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_width (out_width),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    expr_result_unpacker #(.FrameCntInit(16'hFFFF)) dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_data   (90'h155_5555_5555_5555_5555_5555),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
        .out_idx   (w_out_idx),
        .out_data  (w_out_data),
        .out_width (w_out_width),
        .out_last  (w_out_last),
        .frame_cnt (w_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] fwid(input int i);
        case (i % 6)
            0, 3:    return 3'd4;
            1, 4:    return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // Reference field extraction by walking the layout bit by bit.
    function automatic logic [7:0] fdata(input logic [89:0] v, input int i);
        int         off;
        int         w;
        logic [7:0] r;
        off = 0;
        for (int k = 0; k < i; k++) off += int'(fwid(k));
        w = int'(fwid(i));
        r = 8'd0;
        for (int b = 0; b < w; b++) r[b] = v[89 - off - (w - 1) + b];
        if ((i % 6) >= 3 && r[w-1]) begin
            for (int b = w; b < 8; b++) r[b] = 1'b1;
        end
        return r;
    endfunction

    task automatic push_beat(input int i, input logic [7:0] d);
        beat_t e;
        e.idx   = 5'(i);
        e.data  = d;
        e.width = fwid(i);
        e.last  = (i == 17);
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [89:0] v);
        for (int i = 0; i < 18; i++) push_beat(i, fdata(v, i));
    endtask

    task automatic accept(input logic [89:0] v);
        int n;
        n = 0;
        in_data  = v;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        chk("latency1_valid_notready", {30'd0, out_valid, in_ready}, 32'h2);
    endtask

    task automatic stream(input bit toggle);
        int n;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        n = 0;
        while (!in_ready && n < 200) begin
            out_ready = toggle ? pat[n % 4] : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("stream_done_ready", {31'd0, in_ready}, 32'h1);
        chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
        chk("sb_drained", sb.size(), 0);
    endtask

    // Monitor: pops on accepted beats, checks stall stability and idle zeros.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else if (out_valid) begin
            chk("ready_low_in_stream", {31'd0, in_ready}, 32'h0);
            if (stall) begin
                chk("stall_stable", {16'd0, out_idx, out_data, out_width, out_last},
                    {16'd0, held.idx, held.data, held.width, held.last});
            end
            if (out_ready) begin
                stall = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_beat_idx", {27'd0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_idx", {27'd0, out_idx}, {27'd0, e.idx});
                    chk("beat_data", {24'd0, out_data}, {24'd0, e.data});
                    chk("beat_width", {29'd0, out_width}, {29'd0, e.width});
                    chk("beat_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end else begin
                stall      = 1'b1;
                held.idx   = out_idx;
                held.data  = out_data;
                held.width = out_width;
                held.last  = out_last;
            end
        end else begin
            stall = 1'b0;
            chk("idle_outputs", {15'd0, in_ready, out_idx, out_data, out_width, out_last},
                {15'd0, 1'b1, 5'd0, 8'd0, 3'd0, 1'b0});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [89:0] va;
        logic [89:0] vb;
        logic [89:0] vc;
        logic [89:0] vd;
        logic [89:0] ve;
        logic [89:0] vf;
        int          n;
        va = 90'd0;
        va[89:86] = 4'hF;
        vb = 90'd0;
        vb[74:71] = 4'b1000;
        vb[10:6]  = 5'b01111;
        vb[5:0]   = 6'b100001;
        vc = {26'h2F0_C3A5, 64'hDEAD_BEEF_0123_4567};
        vd = {26'h123_4567, 64'hFEDC_BA98_7654_3210};
        ve = {90{1'b1}};
        vf = {26'h2AA_AAAA, 64'h5555_5555_AAAA_AAAA};
        exp_frames = 16'd0;

        // Reset with in_valid already high; acceptance on the first released edge.
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = va;
        out_ready  = 1'b1;
        w_in_valid = 1'b1;
        repeat (3) tick();
        chk("reset_state", {14'd0, in_ready, out_valid, frame_cnt}, {14'd0, 1'b1, 1'b0, 16'd0});
        chk("wrap_preload", {16'd0, w_frame_cnt}, 32'hFFFF);
        for (int i = 0; i < 18; i++) push_beat(i, (i == 0) ? 8'h0F : 8'h00);
        exp_frames = 16'd1;
        rst_n = 1'b1;
        tick();
        in_valid   = 1'b0;
        w_in_valid = 1'b0;
        chk("first_accept", {30'd0, out_valid, in_ready}, 32'h2);
        stream(1'b0);
        chk("frame_cnt_wrap", {16'd0, w_frame_cnt}, 32'h0);

        // Sign-extension corner values, with a stalling consumer.
        for (int i = 0; i < 18; i++) begin
            push_beat(i, (i == 3) ? 8'hF8 : (i == 16) ? 8'h0F : (i == 17) ? 8'hE1 : 8'h00);
        end
        accept(vb);
        exp_frames++;
        stream(1'b1);

        push_model(vf);
        accept(vf);
        exp_frames++;
        stream(1'b1);

        // Reset in the middle of a frame at idx 9.
        push_model(ve);
        accept(ve);
        out_ready = 1'b1;
        n = 0;
        while (out_idx != 5'd9 && n < 50) begin
            tick();
            n++;
        end
        chk("reach_idx9", {27'd0, out_idx}, 32'd9);
        out_ready = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
        chk("midreset_state", {14'd0, in_ready, out_valid, frame_cnt}, {14'd0, 1'b1, 1'b0, 16'd0});
        exp_frames = 16'd0;
        push_model(vc);
        accept(vc);
        exp_frames++;
        stream(1'b0);

        // in_valid held high across two vectors; in_data changes mid-stream.
        in_data  = vc;
        in_valid = 1'b1;
        push_model(vc);
        tick();
        chk("b2b_first_accept", {30'd0, out_valid, in_ready}, 32'h2);
        exp_frames++;
        in_data = vd;
        push_model(vd);
        out_ready = 1'b1;
        repeat (17) tick();
        chk("b2b_busy_at_17", {30'd0, out_valid, in_ready}, 32'h2);
        tick();
        chk("b2b_rearm", {30'd0, out_valid, in_ready}, 32'h1);
        chk("b2b_frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames});
        tick();
        chk("b2b_second_accept", {30'd0, out_valid, in_ready}, 32'h2);
        in_valid = 1'b0;
        exp_frames++;
        stream(1'b0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
